// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: UART receive front end. Synchronises the raw rx line,
// validates the start bit at its centre and emits one-clk strobes at every
// bit centre, driven by the baud-rate generator's oversampling tick.
// Optional parity bit support is compiled in with the UART_RX_PARITY_EN macro;
// without it the frame is start + DATA_BITS + stop and parity_err is tied 0.
module uart_rx_sampler #(
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit PARITY_ODD  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic baud_tick,
  input  logic rx_en,
  input  logic rx_in,
  output logic start_bit,
  output logic get_value,
  output logic rx_bit,
  output logic data_received,
  output logic stop,
  output logic framing_err,
  output logic parity_err,
  output logic rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  state_t state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic rx_s;
  logic armed;
  logic half_hit, full_hit, last_data;
  logic start_set, sample_set, stop_set;

  // Shift the asynchronous line through the synchroniser; idle level is 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
  end

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign half_hit  = baud_tick && (tick_cnt == HALF_LAST);
  assign full_hit  = baud_tick && (tick_cnt == FULL_LAST);
  assign last_data = (bit_cnt == LAST_DATA);
  assign rx_busy   = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: walk start, data, optional parity and stop centres; disable aborts
  always_comb begin
    state_next = state;
    if (!rx_en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:   if (armed && !rx_s) state_next = START;
        START:  if (half_hit) state_next = rx_s ? IDLE : DATA;
        DATA:   if (full_hit && last_data) state_next = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
        PARITY: if (full_hit) state_next = STOP;
`endif
        STOP:   if (full_hit) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode: which bit-centre event happens on this clock edge
  always_comb begin
    start_set  = 1'b0;
    sample_set = 1'b0;
    stop_set   = 1'b0;
    if (rx_en) begin
      start_set  = (state == START) && half_hit && !rx_s;
      sample_set = (state == DATA) && full_hit;
      stop_set   = (state == STOP) && full_hit;
    end
  end

  // Datapath: oversample/bit counters, registered strobes, sampled bit and flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      armed         <= 1'b1;
      start_bit     <= 1'b0;
      get_value     <= 1'b0;
      stop          <= 1'b0;
      rx_bit        <= 1'b0;
      data_received <= 1'b0;
      framing_err   <= 1'b0;
    end else begin
      start_bit <= start_set;
      get_value <= sample_set;
      stop      <= stop_set;

      if (state == IDLE || !rx_en) begin
        tick_cnt <= '0;
      end else if (baud_tick) begin
        if ((state == START && tick_cnt == HALF_LAST) || tick_cnt == FULL_LAST)
          tick_cnt <= '0;
        else
          tick_cnt <= tick_cnt + TW'(1);
      end

      if (state == IDLE && rx_s)
        armed <= 1'b1;
      else if (stop_set && !rx_s)
        armed <= 1'b0;

      if (!rx_en) begin
        bit_cnt       <= '0;
        data_received <= 1'b0;
      end else if (start_set) begin
        bit_cnt     <= '0;
        framing_err <= 1'b0;
      end else if (sample_set) begin
        rx_bit  <= rx_s;
        bit_cnt <= bit_cnt + BW'(1);
        if (last_data) data_received <= 1'b1;
      end else if (stop_set) begin
        framing_err   <= ~rx_s;
        data_received <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_set;
  logic parity_acc;

  assign parity_set = rx_en && (state == PARITY) && full_hit;

  // Running XOR of data bits and parity bit, judged when the stop bit is sampled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_acc <= 1'b0;
      parity_err <= 1'b0;
    end else if (start_set) begin
      parity_acc <= 1'b0;
      parity_err <= 1'b0;
    end else if (sample_set || parity_set) begin
      parity_acc <= parity_acc ^ rx_s;
    end else if (stop_set) begin
      parity_err <= parity_acc ^ PARITY_ODD;
    end
  end
`else
  logic unused_parity_odd;

  assign unused_parity_odd = PARITY_ODD;
  assign parity_err        = 1'b0;
`endif

endmodule
